// File: rtl/laa_responder_if.sv
// LAA bus between the core-side instruction decoder (master) and the accelerator responder (slave).
interface laa_responder_if #(
  parameter int NREG = 32,
  parameter int DW   = 32
);
  localparam int AW = $clog2(NREG);

  logic [1:0]    opcode;
  logic [AW-1:0] addr;
  logic [DW-1:0] datain;
  logic [DW-1:0] dataout;
  logic          dataout_valid;
  logic          busy;
  logic          done;
  logic          cmd_err;

  modport master (
    output opcode, addr, datain,
    input  dataout, dataout_valid, busy, done, cmd_err
  );

  modport slave (
    input  opcode, addr, datain,
    output dataout, dataout_valid, busy, done, cmd_err
  );
endinterface

// File: rtl/laa_responder.sv
// LAA accelerator responder: register bank with READ/WRITE and a pipelined vector dot-product engine.
// Define LAA_ACC_HI_EN for a full-width product/accumulator with the high word written to reg NREG-2.
module laa_responder #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int VLEN = 8
) (
  input  logic           clk,
  input  logic           rst,
  laa_responder_if.slave bus
);
  localparam int AW = $clog2(NREG);
`ifdef LAA_ACC_HI_EN
  localparam int PW = 2 * DW;
`else
  localparam int PW = DW;
`endif
  localparam logic [AW-1:0] RES_ADDR = AW'(NREG - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(VLEN - 1);

  if (2 * VLEN > NREG - 2) begin : g_bad_cfg
    $error("laa_responder: 2*VLEN must not exceed NREG-2");
  end

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, WB} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_MULTIPLY} op_t;

  logic [DW-1:0] regs [NREG];
  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] b_idx;
  logic [PW-1:0] prod_q;
  logic          prod_valid;
  logic [PW-1:0] acc;
  op_t           op;

  assign op    = op_t'(bus.opcode);
  assign b_idx = AW'(VLEN) + idx;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, which the
  // multiply -> accumulate pipeline depends on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register bank is deliberately reset; the bank is small and
      // software relies on it reading zero after reset, including mid-MULTIPLY.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      state             <= IDLE;
      idx               <= '0;
      prod_q            <= '0;
      prod_valid        <= 1'b0;
      acc               <= '0;
      bus.dataout       <= '0;
      bus.dataout_valid <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.cmd_err       <= 1'b0;
    end else begin
      bus.dataout_valid <= 1'b0;
      bus.done          <= 1'b0;
      bus.cmd_err       <= 1'b0;
      prod_valid        <= 1'b0;

      // Second pipe stage: fold in whatever product the first stage produced.
      if (prod_valid) acc <= acc + prod_q;

      case (state)
        IDLE: begin
          case (op)
            OP_WRITE: regs[bus.addr] <= bus.datain;
            OP_READ: begin
              bus.dataout       <= regs[bus.addr];
              bus.dataout_valid <= 1'b1;
            end
            OP_MULTIPLY: begin
              state    <= MAC;
              bus.busy <= 1'b1;
              idx      <= '0;
              acc      <= '0;
            end
            default: ;
          endcase
        end
        MAC: begin
          prod_q     <= PW'(regs[idx]) * PW'(regs[b_idx]);
          prod_valid <= 1'b1;
          idx        <= idx + 1'b1;
          if (idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: state <= WB;
        WB: begin
          regs[RES_ADDR] <= acc[DW-1:0];
`ifdef LAA_ACC_HI_EN
          regs[AW'(NREG - 2)] <= acc[PW-1:DW];
`endif
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Anything arriving outside IDLE is dropped and flagged.
      if (state != IDLE && op != OP_NONE) bus.cmd_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_laa_responder.sv
// Scoreboard bench for laa_responder: a driver predicts responses from a register-array model,
// a negedge monitor checks every output pulse against the queued expectations.
module tb_laa_responder;
  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int VLEN = 8;

  localparam logic [1:0] NONE = 2'd0, READ = 2'd1, WRITE = 2'd2, MULT = 2'd3;

  typedef struct {
    int          at_edge;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  laa_responder_if #(.NREG(NREG), .DW(DW)) bus ();

  laa_responder #(.NREG(NREG), .DW(DW), .VLEN(VLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int edges = 0;

  logic [31:0] mdl [NREG];
  int          busy_left = 0;
  exp_t        rd_q[$];
  exp_t        done_q[$];
  exp_t        err_q[$];

  always @(posedge clk) edges++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Dot product straight from the operand layout; the low word is identical
  // whether products are truncated or kept full width.
  function automatic logic [63:0] dot_product();
    logic [63:0] sum = 64'd0;
    for (int i = 0; i < VLEN; i++) sum += 64'(mdl[i]) * 64'(mdl[VLEN + i]);
    return sum;
  endfunction

  // One command slot: presented at the negedge, sampled by the next posedge.
  task automatic cycle(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    int          k;
    logic [63:0] sum;
    @(negedge clk);
    check("busy", 64'(bus.busy), 64'(busy_left > 0));
    bus.opcode = op;
    bus.addr   = a;
    bus.datain = d;
    k = edges + 1;
    if (busy_left > 0) begin
      busy_left--;
      if (op != NONE) err_q.push_back('{k, 32'd0});
    end else begin
      case (op)
        WRITE: mdl[a] = d;
        READ:  rd_q.push_back('{k, mdl[a]});
        MULT: begin
          sum = dot_product();
          mdl[NREG-1] = sum[31:0];
`ifdef LAA_ACC_HI_EN
          mdl[NREG-2] = sum[63:32];
`endif
          busy_left = VLEN + 2;
          done_q.push_back('{k + VLEN + 2, 32'd0});
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(NONE, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    rd_q.delete();
    done_q.delete();
    err_q.delete();
    busy_left = 0;
    for (int i = 0; i < NREG; i++) mdl[i] = 32'd0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_cmd_err", 64'(bus.cmd_err), 64'd0);
    check("rst_dataout", 64'(bus.dataout), 64'd0);
    check("rst_dataout_valid", 64'(bus.dataout_valid), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.dataout_valid) begin
        if (rd_q.size() == 0) check("unexpected_dataout_valid", 64'd1, 64'd0);
        else begin
          e = rd_q.pop_front();
          check("read_timing", 64'(edges), 64'(e.at_edge));
          check("read_data", 64'(bus.dataout), 64'(e.data));
        end
      end
      while (rd_q.size() > 0 && rd_q[0].at_edge < edges) begin
        e = rd_q.pop_front();
        check("missing_dataout_valid", 64'd0, 64'd1);
      end
      if (bus.done) begin
        if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else begin
          e = done_q.pop_front();
          check("done_timing", 64'(edges), 64'(e.at_edge));
          check("done_busy_low", 64'(bus.busy), 64'd0);
        end
      end
      while (done_q.size() > 0 && done_q[0].at_edge < edges) begin
        e = done_q.pop_front();
        check("missing_done", 64'd0, 64'd1);
      end
      if (bus.cmd_err) begin
        if (err_q.size() == 0) check("unexpected_cmd_err", 64'd1, 64'd0);
        else begin
          e = err_q.pop_front();
          check("cmd_err_timing", 64'(edges), 64'(e.at_edge));
        end
      end
      while (err_q.size() > 0 && err_q[0].at_edge < edges) begin
        e = err_q.pop_front();
        check("missing_cmd_err", 64'd0, 64'd1);
      end
    end
  end

  initial begin
    bus.opcode = NONE;
    bus.addr   = '0;
    bus.datain = '0;
    for (int i = 0; i < NREG; i++) mdl[i] = 32'd0;
    do_reset();

    // Write then read back; neighbours stay zero.
    cycle(WRITE, 5'd5, 32'hDEADBEEF);
    cycle(READ, 5'd5, 32'd0);
    cycle(READ, 5'd6, 32'd0);
    cycle(READ, 5'd0, 32'd0);
    cycle(READ, 5'd31, 32'd0);

    // 1..8 . 1..8 = 204
    for (int i = 0; i < VLEN; i++) begin
      cycle(WRITE, 5'(i), 32'(i + 1));
      cycle(WRITE, 5'(VLEN + i), 32'(i + 1));
    end
    cycle(MULT, 5'd0, 32'd0);
    idle(VLEN + 2);
    cycle(READ, 5'd31, 32'd0);
    cycle(READ, 5'd3, 32'd0);

    // Wrap case, with two illegal commands while busy.
    for (int i = 0; i < VLEN; i++) begin
      cycle(WRITE, 5'(i), 32'hFFFFFFFF);
      cycle(WRITE, 5'(VLEN + i), 32'd2);
    end
    cycle(MULT, 5'd0, 32'd0);
    idle(2);
    cycle(WRITE, 5'd0, 32'h1234);
    cycle(READ, 5'd0, 32'd0);
    idle(VLEN);
    cycle(READ, 5'd31, 32'd0);
    cycle(READ, 5'd30, 32'd0);
    cycle(READ, 5'd0, 32'd0);

    // Back-to-back MULTIPLY issued in the done cycle.
    cycle(MULT, 5'd0, 32'd0);
    idle(VLEN + 2);
    cycle(MULT, 5'd0, 32'd0);
    idle(VLEN + 2);
    cycle(READ, 5'd31, 32'd0);

    // Reset in the middle of MAC, then a normal MULTIPLY.
    cycle(MULT, 5'd0, 32'd0);
    idle(4);
    do_reset();
    cycle(READ, 5'd31, 32'd0);
    cycle(READ, 5'd0, 32'd0);
    cycle(READ, 5'd8, 32'd0);
    for (int i = 0; i < 2 * VLEN; i++) cycle(WRITE, 5'(i), $urandom);
    cycle(MULT, 5'd0, 32'd0);
    idle(VLEN + 2);
    cycle(READ, 5'd31, 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [1:0]  op;
      r  = $urandom_range(0, 99);
      op = (r < 25) ? NONE : (r < 55) ? READ : (r < 94) ? WRITE : MULT;
      cycle(op, 5'($urandom_range(0, NREG - 1)), $urandom);
    end
    idle(VLEN + 4);
    for (int i = 0; i < NREG; i++) cycle(READ, 5'(i), 32'd0);
    idle(4);

    check("pending_reads", 64'(rd_q.size()), 64'd0);
    check("pending_done", 64'(done_q.size()), 64'd0);
    check("pending_cmd_err", 64'(err_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/laa_responder.md
Name: laa_responder

Overview:
- Accelerator-side responder on the LAA bus. Receives per-cycle commands (opcode, addr, datain) from the core-side instruction decoder and executes them.
- Holds the LAA register bank. Services READ and WRITE. Runs a multi-cycle MULTIPLY (vector dot-product) engine, reporting busy/done back to the decoder.

Parameters:
- NREG, 32, number of LAA registers; addr width is clog2(NREG).
- DW, 32, register data width.
- VLEN, 8, dot-product length.
  - Operand A occupies regs 0..VLEN-1; operand B occupies regs VLEN..2*VLEN-1.
  - Result goes to reg NREG-1.
  - Constraint: 2*VLEN <= NREG-2 (elaboration error otherwise).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  2  NONE=0, READ=1, WRITE=2, MULTIPLY=3; any non-NONE value is a command this cycle
- addr  in  clog2(NREG)  register address for READ/WRITE; ignored for MULTIPLY
- datain  in  DW  write data for WRITE
- dataout  out  DW  registered read data
- dataout_valid  out  1  one-cycle pulse, dataout updated
- busy  out  1  MULTIPLY in progress; commands not accepted
- done  out  1  one-cycle pulse, result written to reg NREG-1
- cmd_err  out  1  one-cycle pulse, command arrived while busy and was dropped

Behaviour:
- Reset (async, any time including mid-MULTIPLY):
  - All registers cleared to 0.
  - FSM returns to IDLE.
  - dataout, dataout_valid, busy, done, cmd_err all 0.
  - Index and accumulator cleared.
- Commands are sampled only in IDLE, one per rising edge.
- WRITE: reg[addr] <= datain at the sampling edge. No output pulse.
- READ:
  - dataout <= reg[addr] at the sampling edge; dataout_valid high for the following cycle.
  - dataout holds its value until the next READ.
  - A READ in the cycle after a WRITE to the same addr returns the new value.
- MULTIPLY: at the sampling edge, FSM goes IDLE->MAC; busy rises; idx=0; acc=0.
- FSM states: IDLE, MAC, DRAIN, WB.
  - MAC: each cycle, prod_q <= reg[idx]*reg[VLEN+idx] (low DW bits); idx++. After issuing idx=VLEN-1, go to DRAIN.
  - Accumulate pipeline: acc <= acc + prod_q on every edge where prod_q holds a valid product (2-stage pipe: multiply register, then accumulate).
  - DRAIN: last product is accumulated; go to WB.
  - WB: reg[NREG-1] <= final sum; done pulses for 1 cycle; busy drops; return to IDLE.
  - Timing: busy is high for exactly VLEN+2 cycles. done is high in the cycle after the WB edge and coincides with busy=0.
- Arithmetic: unsigned; product truncated to DW bits; accumulation wraps mod 2^DW.
- Commands during busy:
  - No register, dataout, or FSM effect.
  - cmd_err pulses in the following cycle.
  - Multiple back-to-back illegal commands give one pulse each.
- Operand registers may be read back after done. Register contents other than NREG-1 (and NREG-2 under the optional feature) are unchanged by MULTIPLY.
- A new command is accepted in the cycle done is high, since the FSM is IDLE.

Optional Feature:
- Macro LAA_ACC_HI_EN.
- Defined:
  - Product kept at full 2*DW bits; accumulator is 2*DW bits, wrapping mod 2^(2*DW).
  - WB writes the low word to reg NREG-1 and the high word to reg NREG-2 on the same edge.
- Undefined: DW-bit truncated behaviour as above; reg NREG-2 is an ordinary register.

Test Plan:
- WRITE addr 5 = 0xDEADBEEF, next cycle READ 5 -> dataout=0xDEADBEEF with dataout_valid=1 one cycle after READ; other registers read 0.
- VLEN=8: regs 0..7 = 1..8, regs 8..15 = 1..8, MULTIPLY -> busy high 10 cycles, then done pulse; READ 31 -> 0x000000CC (204).
- Regs 0..7 = 0xFFFFFFFF, regs 8..15 = 2, MULTIPLY:
  - Without macro: reg31 = 0xFFFFFFF0.
  - With LAA_ACC_HI_EN: reg31 = 0xFFFFFFF0 and reg30 = 0x0000000F.
- During busy, issue WRITE 0 = 0x1234 then READ 0 -> two cmd_err pulses, no dataout_valid, reg0 unchanged; result unaffected.
- Assert rst at MAC cycle 4 -> busy=0, done never pulses, all regs (including 31) read 0 afterwards; a new MULTIPLY then runs normally.
- MULTIPLY issued in the done cycle of a previous MULTIPLY is accepted (no cmd_err); second result equals first for unchanged operands.
